// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Every bit is held for BIT_CYCLES clocks; q idles high.
module serial_frame_tx #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned BIT_CYCLES = 4,
    parameter int unsigned PARITY_EN  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             q,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cyc, cyc_d;
    logic [BW-1:0]    bitc, bit_d;
    logic [WIDTH-1:0] shift, shift_d;
    logic             par, par_d;
    logic             q_d, busy_d, done_d;
    logic             ready_en;
    logic             last_cyc;
    logic             handshake;

    // ready_en keeps load_ready low until the first edge after reset release
    assign last_cyc   = (cyc == CYC_LAST);
    assign load_ready = ready_en && ((state == IDLE) || ((state == STOP) && last_cyc));
    assign handshake  = load_valid && load_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cyc      <= '0;
            bitc     <= '0;
            shift    <= '0;
            par      <= 1'b0;
            q        <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_d;
            cyc      <= cyc_d;
            bitc     <= bit_d;
            shift    <= shift_d;
            par      <= par_d;
            q        <= q_d;
            busy     <= busy_d;
            done     <= done_d;
            ready_en <= 1'b1;
        end
    end

    // Next state and counters; outputs are decoded from the next state so they register in step
    always_comb begin
        state_d = state;
        cyc_d   = cyc;
        bit_d   = bitc;
        shift_d = shift;
        par_d   = par;
        q_d     = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state)
            IDLE: begin
                if (handshake) begin
                    state_d = START;
                    cyc_d   = '0;
                    bit_d   = '0;
                    shift_d = data_in;
                    par_d   = ^data_in;
                end
            end
            START: begin
                if (last_cyc) begin
                    state_d = DATA;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc + CW'(1);
                end
            end
            DATA: begin
                if (last_cyc) begin
                    cyc_d   = '0;
                    shift_d = shift >> 1;
                    if (bitc == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bitc + BW'(1);
                    end
                end else begin
                    cyc_d = cyc + CW'(1);
                end
            end
            PARITY: begin
                if (last_cyc) begin
                    state_d = STOP;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc + CW'(1);
                end
            end
            STOP: begin
                if (last_cyc) begin
                    cyc_d = '0;
                    if (handshake) begin
                        state_d = START;
                        bit_d   = '0;
                        shift_d = data_in;
                        par_d   = ^data_in;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cyc_d = cyc + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   q_d = 1'b0;
            DATA:    q_d = shift_d[0];
            PARITY:  q_d = par_d;
            default: q_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (cyc_d == CYC_LAST);
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: default build, no-parity build and single-cycle-bit build.
`timescale 1ns/1ps
module tb_serial_frame_tx;

    logic       clk;
    logic       reset;
    logic [7:0] data_in;
    logic       lv0, lv1, lv2;
    logic       lr0, lr1, lr2;
    logic       q0, q1, q2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;

    int checks   = 0;
    int failures = 0;

    logic cap_q [1:100];
    logic cap_b [1:100];
    logic cap_d [1:100];
    logic cap_r [1:100];

    serial_frame_tx #(.WIDTH(8), .BIT_CYCLES(4), .PARITY_EN(1)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .load_valid(lv0),
        .load_ready(lr0), .q(q0), .busy(busy0), .done(done0));

    serial_frame_tx #(.WIDTH(8), .BIT_CYCLES(4), .PARITY_EN(0)) dut_np (
        .clk(clk), .reset(reset), .data_in(data_in), .load_valid(lv1),
        .load_ready(lr1), .q(q1), .busy(busy1), .done(done1));

    serial_frame_tx #(.WIDTH(8), .BIT_CYCLES(1), .PARITY_EN(1)) dut_bc1 (
        .clk(clk), .reset(reset), .data_in(data_in), .load_valid(lv2),
        .load_ready(lr2), .q(q2), .busy(busy2), .done(done2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_lv(input int sel, input logic v);
        case (sel)
            0: lv0 = v;
            1: lv1 = v;
            default: lv2 = v;
        endcase
    endtask

    // Handshake one word into instance sel, then record n cycles of outputs (cycle 1 follows the handshake edge)
    task automatic capture(input int sel, input logic [7:0] word, input int n, input bit b2b, input bit noisy);
        @(posedge clk); #1;
        data_in = word;
        set_lv(sel, 1'b1);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            case (sel)
                0: begin cap_q[k] = q0; cap_b[k] = busy0; cap_d[k] = done0; cap_r[k] = lr0; end
                1: begin cap_q[k] = q1; cap_b[k] = busy1; cap_d[k] = done1; cap_r[k] = lr1; end
                default: begin cap_q[k] = q2; cap_b[k] = busy2; cap_d[k] = done2; cap_r[k] = lr2; end
            endcase
            if (b2b) begin
                if (k == 44) data_in = 8'hFF;
                if (k == 45) set_lv(sel, 1'b0);
            end else if (k == 1) begin
                set_lv(sel, 1'b0);
            end
            if (noisy && k >= 10 && k <= 20) begin
                set_lv(sel, (k % 2) == 1);
                data_in = 8'h3C;
            end
            if (noisy && k == 21) set_lv(sel, 1'b0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; data_in = 8'h00; lv0 = 1'b0; lv1 = 1'b0; lv2 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++; if (q0 !== 1'b1) begin failures++; $display("FAIL reset_q cyc%0d got %b want 1", c, q0); end
            checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy cyc%0d got %b want 0", c, busy0); end
            checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL reset_done cyc%0d got %b want 0", c, done0); end
            checks++; if (lr0 !== 1'b0) begin failures++; $display("FAIL reset_ready cyc%0d got %b want 0", c, lr0); end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if ({lr0, lr1, lr2} !== 3'b111) begin failures++; $display("FAIL ready_after_reset got %b want 111", {lr0, lr1, lr2}); end
        checks++; if ({q0, busy0, done0} !== 3'b100) begin failures++; $display("FAIL idle_after_reset q/busy/done got %b want 100", {q0, busy0, done0}); end
    endtask

    task automatic test_frame_a5();
        logic [0:10] s;
        s = 11'b0_10100101_0_1;
        capture(0, 8'hA5, 44, 1'b0, 1'b0);
        for (int k = 1; k <= 44; k++) begin
            checks++; if (cap_q[k] !== s[(k-1)/4]) begin failures++; $display("FAIL a5_q cyc%0d got %b want %b", k, cap_q[k], s[(k-1)/4]); end
            checks++; if (cap_d[k] !== (k == 44)) begin failures++; $display("FAIL a5_done cyc%0d got %b want %b", k, cap_d[k], k == 44); end
            checks++; if (cap_r[k] !== (k == 44)) begin failures++; $display("FAIL a5_ready cyc%0d got %b want %b", k, cap_r[k], k == 44); end
            checks++; if (cap_b[k] !== 1'b1) begin failures++; $display("FAIL a5_busy cyc%0d got %b want 1", k, cap_b[k]); end
        end
        @(posedge clk); #1;
        checks++; if ({q0, busy0, done0, lr0} !== 4'b1001) begin failures++; $display("FAIL a5_idle q/busy/done/ready got %b want 1001", {q0, busy0, done0, lr0}); end
    endtask

    task automatic test_parity();
        logic [0:9] s;
        s = 10'b0_10000000_1;
        capture(0, 8'h01, 44, 1'b0, 1'b0);
        for (int k = 37; k <= 40; k++) begin
            checks++; if (cap_q[k] !== 1'b1) begin failures++; $display("FAIL par01_bit cyc%0d got %b want 1", k, cap_q[k]); end
        end
        checks++; if (cap_q[5] !== 1'b1 || cap_q[9] !== 1'b0) begin failures++; $display("FAIL par01_data got b0=%b b1=%b want b0=1 b1=0", cap_q[5], cap_q[9]); end
        @(posedge clk); #1;
        capture(1, 8'h01, 40, 1'b0, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            checks++; if (cap_q[k] !== s[(k-1)/4]) begin failures++; $display("FAIL nopar_q cyc%0d got %b want %b", k, cap_q[k], s[(k-1)/4]); end
            checks++; if (cap_d[k] !== (k == 40)) begin failures++; $display("FAIL nopar_done cyc%0d got %b want %b", k, cap_d[k], k == 40); end
            checks++; if (cap_b[k] !== 1'b1) begin failures++; $display("FAIL nopar_busy cyc%0d got %b want 1", k, cap_b[k]); end
        end
        @(posedge clk); #1;
        checks++; if ({q1, busy1, lr1} !== 3'b101) begin failures++; $display("FAIL nopar_idle q/busy/ready got %b want 101", {q1, busy1, lr1}); end
    endtask

    task automatic test_bit_cycles_1();
        logic [0:10] s;
        s = 11'b0_10100101_0_1;
        capture(2, 8'hA5, 11, 1'b0, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            checks++; if (cap_q[k] !== s[k-1]) begin failures++; $display("FAIL bc1_q cyc%0d got %b want %b", k, cap_q[k], s[k-1]); end
            checks++; if (cap_d[k] !== (k == 11)) begin failures++; $display("FAIL bc1_done cyc%0d got %b want %b", k, cap_d[k], k == 11); end
            checks++; if (cap_r[k] !== (k == 11)) begin failures++; $display("FAIL bc1_ready cyc%0d got %b want %b", k, cap_r[k], k == 11); end
            checks++; if (cap_b[k] !== 1'b1) begin failures++; $display("FAIL bc1_busy cyc%0d got %b want 1", k, cap_b[k]); end
        end
        @(posedge clk); #1;
        checks++; if ({q2, busy2, done2} !== 3'b100) begin failures++; $display("FAIL bc1_idle q/busy/done got %b want 100", {q2, busy2, done2}); end
    endtask

    task automatic test_back_to_back();
        logic [0:10] sa;
        logic [0:10] sb;
        logic        e;
        sa = 11'b0_00000000_0_1;
        sb = 11'b0_11111111_0_1;
        capture(0, 8'h00, 88, 1'b1, 1'b0);
        for (int k = 1; k <= 88; k++) begin
            e = (k <= 44) ? sa[(k-1)/4] : sb[(k-45)/4];
            checks++; if (cap_q[k] !== e) begin failures++; $display("FAIL b2b_q cyc%0d got %b want %b", k, cap_q[k], e); end
            checks++; if (cap_d[k] !== (k == 44 || k == 88)) begin failures++; $display("FAIL b2b_done cyc%0d got %b want %b", k, cap_d[k], k == 44 || k == 88); end
            checks++; if (cap_b[k] !== 1'b1) begin failures++; $display("FAIL b2b_busy cyc%0d got %b want 1", k, cap_b[k]); end
        end
        @(posedge clk); #1;
        checks++; if ({q0, busy0} !== 2'b10) begin failures++; $display("FAIL b2b_idle q/busy got %b want 10", {q0, busy0}); end
    endtask

    task automatic test_busy_inputs();
        logic [0:10] s;
        s = 11'b0_10100101_0_1;
        capture(0, 8'hA5, 44, 1'b0, 1'b1);
        for (int k = 1; k <= 44; k++) begin
            checks++; if (cap_q[k] !== s[(k-1)/4]) begin failures++; $display("FAIL noisy_q cyc%0d got %b want %b", k, cap_q[k], s[(k-1)/4]); end
            checks++; if (cap_d[k] !== (k == 44)) begin failures++; $display("FAIL noisy_done cyc%0d got %b want %b", k, cap_d[k], k == 44); end
        end
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++; if ({q0, busy0, done0} !== 3'b100) begin failures++; $display("FAIL noisy_no_extra cyc%0d q/busy/done got %b want 100", c, {q0, busy0, done0}); end
        end
    endtask

    task automatic test_reset_mid();
        logic [0:10] s;
        s = 11'b0_01011010_0_1;
        capture(0, 8'h5A, 10, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            checks++; if (cap_q[k] !== s[(k-1)/4]) begin failures++; $display("FAIL mid_pre_q cyc%0d got %b want %b", k, cap_q[k], s[(k-1)/4]); end
        end
        reset = 1'b0;
        #1;
        checks++; if ({q0, busy0, done0, lr0} !== 4'b1000) begin failures++; $display("FAIL mid_async q/busy/done/ready got %b want 1000", {q0, busy0, done0, lr0}); end
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++; if ({busy0, done0} !== 2'b00) begin failures++; $display("FAIL mid_hold cyc%0d busy/done got %b want 00", c, {busy0, done0}); end
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (lr0 !== 1'b1) begin failures++; $display("FAIL mid_ready got %b want 1", lr0); end
        capture(0, 8'h5A, 44, 1'b0, 1'b0);
        for (int k = 1; k <= 44; k++) begin
            checks++; if (cap_q[k] !== s[(k-1)/4]) begin failures++; $display("FAIL mid_5a_q cyc%0d got %b want %b", k, cap_q[k], s[(k-1)/4]); end
            checks++; if (cap_d[k] !== (k == 44)) begin failures++; $display("FAIL mid_5a_done cyc%0d got %b want %b", k, cap_d[k], k == 44); end
        end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_parity();
        test_bit_cycles_1();
        test_back_to_back();
        test_busy_inputs();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-to-serial frame transmitter. Drives the single-bit serial line that our flip-flop/receiver blocks sample on `d`.
- Accepts a WIDTH-bit word through a valid/ready handshake. Emits one frame: start bit, data LSB-first, optional even parity, stop bit.
- Each bit is held for BIT_CYCLES clocks.
- Sits between a word producer (bench or control logic) and any serial sampler in the design.

Parameters:
- WIDTH, 8, data bits per frame (1..32).
- BIT_CYCLES, 4, clock cycles each bit is held on q (>=1).
- PARITY_EN, 1, 1 = append even-parity bit after data; 0 = no parity bit.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  WIDTH  word to transmit; sampled only on handshake.
- load_valid  input  1  producer has a word on data_in.
- load_ready  output  1  transmitter can accept a word this cycle.
- q  output  1  serial line; idle level 1.
- busy  output  1  frame in progress (any state other than IDLE).
- done  output  1  one-cycle pulse in the final cycle of the stop bit.

Behaviour:
- Single clock domain. All outputs are registered, except load_ready, which is a decode of state and counters.
- Reset (reset=0, asynchronous): outputs are forced immediately to:
  - q=1, busy=0, done=0, load_ready=0 while reset is held.
  - Internal state: IDLE; bit counter 0; cycle counter 0; shift register 0.
- After reset release: load_ready=1 from the first clock edge onward.
- Reset mid-frame: the frame is abandoned with no partial resumption. q returns to 1 immediately.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - q=1, busy=0, load_ready=1.
  - A handshake is load_valid=1 and load_ready=1 at a rising edge.
  - On handshake: latch data_in into the shift register, clear the counters, go to START.
- Cycle counter counts 0..BIT_CYCLES-1 in every non-IDLE state. A state advances only when the counter equals BIT_CYCLES-1.
- START: q=0 for BIT_CYCLES cycles, then go to DATA.
- DATA:
  - q = shift_reg[0]. The register shifts right once at the end of each bit period.
  - Bit counter runs 0..WIDTH-1.
  - After the last bit: go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: q = XOR of the latched word (even parity: total ones in data+parity is even). Hold BIT_CYCLES cycles, then go to STOP.
- STOP: q=1 for BIT_CYCLES cycles. done=1 only in the final cycle of STOP.
- Back-to-back frames:
  - load_ready is also 1 in the final STOP cycle.
  - A handshake there moves directly to START with no idle gap.
  - Without a handshake there, the FSM goes to IDLE.
- load_ready=0 in all other STOP cycles and in START/DATA/PARITY.
  - load_valid is ignored there.
  - data_in changes after the handshake do not affect the frame in flight.
- Latency: handshake at edge N gives q=0 in the cycle following edge N.
- Frame length: (2 + WIDTH + PARITY_EN) x BIT_CYCLES cycles.
- busy=1 from the START entry edge through the last STOP cycle. busy stays 1 continuously across a back-to-back transition.
- BIT_CYCLES=1 is legal: each bit lasts one cycle and done is asserted for that one STOP cycle.

Test Plan:
- Defaults (WIDTH=8, BIT_CYCLES=4, PARITY_EN=1); reset low for 3 cycles, then high → q=1, busy=0, done=0 throughout reset; load_ready=1 after the first edge.
- Send 0xA5 → q sequence per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1. Frame is 44 cycles; done pulses once at cycle 44; load_ready=0 from cycle 1 to cycle 43.
- Send 0x01 with PARITY_EN=1 → parity bit 1. Rebuild with PARITY_EN=0 → frame is 40 cycles, stop follows data bit 7 directly.
- Back-to-back: hold load_valid=1 with 0x00, then 0xFF presented at the final STOP cycle → second START begins the next cycle, busy never drops, two done pulses 44 cycles apart.
- Busy-time stimulus: toggle load_valid and change data_in to 0x3C during DATA of a 0xA5 frame → transmitted bits remain 0xA5; no extra frame is produced.
- Reset asserted at cycle 10 of a frame → q=1 and busy=0 immediately (before the next edge), no done pulse. After release, a new 0x5A frame transmits correctly from START.
